// File: rtl/packet_router_if.sv
// Packetizer-side and queue-side signals of packet_router, bundled with master (driver) and slave (router) views.
interface packet_router_if #(
  parameter int NUM_INPUTS       = 2,
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int QID_WIDTH        = $clog2(NUMBER_OF_QUEUES)
);
  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0]       in_packet;
  logic [NUM_INPUTS-1:0]                      in_valid;
  logic [NUM_INPUTS-1:0][QID_WIDTH-1:0]       in_id;
  logic [NUM_INPUTS-1:0]                      in_ready;
  logic [NUMBER_OF_QUEUES-1:0]                queue_full;
  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0] out_packet;
  logic [NUMBER_OF_QUEUES-1:0]                out_valid;
  logic [NUM_INPUTS-1:0]                      invalid_id;

  modport master (
    output in_packet, in_valid, in_id, queue_full,
    input  in_ready, out_packet, out_valid, invalid_id
  );

  modport slave (
    input  in_packet, in_valid, in_id, queue_full,
    output in_ready, out_packet, out_valid, invalid_id
  );
endinterface

// File: rtl/packet_router.sv
// Routes packets from NUM_INPUTS holding registers to NUMBER_OF_QUEUES queue write ports by queue id.
// Define ROUTER_ROUND_ROBIN_EN for per-queue round-robin arbitration; otherwise the lowest input index wins.
module packet_router #(
  parameter int NUM_INPUTS       = 2,
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int QID_WIDTH        = $clog2(NUMBER_OF_QUEUES)
) (
  input logic           i_clock,
  input logic           i_reset_n,
  packet_router_if.slave bus
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS-1:0]                      r_holdValid;
  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0]       r_holdPacket;
  logic [NUM_INPUTS-1:0][QID_WIDTH-1:0]       r_holdId;
  logic [NUM_INPUTS-1:0]                      r_invalidId;
  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0] r_outPacket;
  logic [NUMBER_OF_QUEUES-1:0]                r_outValid;

  logic [NUMBER_OF_QUEUES-1:0][NUM_INPUTS-1:0] w_request;
  logic [NUMBER_OF_QUEUES-1:0][NUM_INPUTS-1:0] w_grant;
  logic [NUMBER_OF_QUEUES-1:0]                 w_grantAny;
  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0]  w_grantPacket;
  logic [NUM_INPUTS-1:0]                       w_granted;
  logic [NUM_INPUTS-1:0]                       w_ready;
  logic [NUM_INPUTS-1:0]                       w_accept;
  logic [NUM_INPUTS-1:0]                       w_idOk;

  always_comb begin
    w_request = '0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++)
      for (int i = 0; i < NUM_INPUTS; i++)
        w_request[q][i] = r_holdValid[i] && (int'(r_holdId[i]) == q);
  end

`ifdef ROUTER_ROUND_ROBIN_EN
  logic [NUMBER_OF_QUEUES-1:0][IDX_W-1:0] r_lastGrant;
  logic [NUMBER_OF_QUEUES-1:0][IDX_W-1:0] w_grantIdx;

  // Inputs above the last winner are searched first, then the search wraps to index 0.
  always_comb begin
    w_grant    = '0;
    w_grantAny = '0;
    w_grantIdx = '0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        if (!bus.queue_full[q] && !w_grantAny[q] && (i > int'(r_lastGrant[q])) && w_request[q][i]) begin
          w_grant[q][i] = 1'b1;
          w_grantAny[q] = 1'b1;
          w_grantIdx[q] = IDX_W'(i);
        end
      for (int i = 0; i < NUM_INPUTS; i++)
        if (!bus.queue_full[q] && !w_grantAny[q] && (i <= int'(r_lastGrant[q])) && w_request[q][i]) begin
          w_grant[q][i] = 1'b1;
          w_grantAny[q] = 1'b1;
          w_grantIdx[q] = IDX_W'(i);
        end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++)
        r_lastGrant[q] <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++)
        if (w_grantAny[q])
          r_lastGrant[q] <= w_grantIdx[q];
    end
  end
`else
  always_comb begin
    w_grant    = '0;
    w_grantAny = '0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++)
      for (int i = 0; i < NUM_INPUTS; i++)
        if (!bus.queue_full[q] && !w_grantAny[q] && w_request[q][i]) begin
          w_grant[q][i] = 1'b1;
          w_grantAny[q] = 1'b1;
        end
  end
`endif

  always_comb begin
    w_granted     = '0;
    w_grantPacket = '0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      w_granted = w_granted | w_grant[q];
      for (int i = 0; i < NUM_INPUTS; i++)
        if (w_grant[q][i])
          w_grantPacket[q] = r_holdPacket[i];
    end
  end

  always_comb begin
    w_idOk = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      w_idOk[i] = int'(bus.in_id[i]) < NUMBER_OF_QUEUES;
  end

  // A hold being drained this cycle can take a new packet on the same edge.
  assign w_ready  = {NUM_INPUTS{i_reset_n}} & (~r_holdValid | w_granted);
  assign w_accept = bus.in_valid & w_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_holdValid  <= '0;
      r_holdPacket <= '0;
      r_holdId     <= '0;
      r_invalidId  <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_invalidId[i] <= w_accept[i] & ~w_idOk[i];
        if (w_accept[i]) begin
          r_holdValid[i]  <= w_idOk[i];
          r_holdPacket[i] <= bus.in_packet[i];
          r_holdId[i]     <= bus.in_id[i];
        end else if (w_granted[i]) begin
          r_holdValid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_outValid  <= '0;
      r_outPacket <= '0;
    end else begin
      r_outValid <= w_grantAny;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++)
        if (w_grantAny[q])
          r_outPacket[q] <= w_grantPacket[q];
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_packet = r_outPacket;
  assign bus.out_valid  = r_outValid;
  assign bus.invalid_id = r_invalidId;

endmodule

// File: tb/tb_packet_router.sv
// Self-checking bench for packet_router: directed scenarios plus random traffic against a queue-level reference model.
module tb_packet_router;

  localparam int NI = 2;
  localparam int NQ = 4;
  localparam int DW = 678;
  localparam int QW = 2;

  typedef struct {
    int             id;
    logic [DW-1:0]  data;
  } pkt_t;

  typedef struct {
    int             q;
    logic [DW-1:0]  data;
  } out_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  packet_router_if #(.NUM_INPUTS(NI), .NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DW)) bus ();
  packet_router #(.NUM_INPUTS(NI), .NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DW)) dut (
    .i_clock  (clk),
    .i_reset_n(rstN),
    .bus      (bus)
  );

  // Second instance with a non power-of-two queue count so out-of-range ids are reachable.
  packet_router_if #(.NUM_INPUTS(2), .NUMBER_OF_QUEUES(3), .DATA_SIZE(8)) busB ();
  packet_router #(.NUM_INPUTS(2), .NUMBER_OF_QUEUES(3), .DATA_SIZE(8)) dutB (
    .i_clock  (clk),
    .i_reset_n(rstN),
    .bus      (busB)
  );

  int errors = 0;
  int checks = 0;

  pkt_t pktQ0[$];
  pkt_t pktQ1[$];
  out_t outLog[$];
  logic [NQ-1:0] fullVec;

  bit            mHoldValid[NI];
  logic [DW-1:0] mHoldPkt[NI];
  int            mHoldId[NI];
  int            mWinner[NQ];
  logic [DW-1:0] mOutPkt[NQ];
  logic [NQ-1:0] mOutValid;
  logic [NI-1:0] mInvalid;
  logic [NI-1:0] mReady;
`ifdef ROUTER_ROUND_ROBIN_EN
  int            mLast[NQ];
`endif

  logic          acc[NI];
  int            accId[NI];
  logic [DW-1:0] accData[NI];

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    logic [703:0] tmp;
    for (int w = 0; w < 22; w++) tmp[w*32 +: 32] = $urandom;
    return tmp[DW-1:0];
  endfunction

  task automatic pushPkt(input int port, input int id, input logic [DW-1:0] data);
    pkt_t p;
    p.id   = id;
    p.data = data;
    if (port == 0) pktQ0.push_back(p);
    else           pktQ1.push_back(p);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mHoldValid[i] = 1'b0;
      mHoldPkt[i]   = '0;
      mHoldId[i]    = 0;
    end
    for (int q = 0; q < NQ; q++) begin
      mOutPkt[q] = '0;
`ifdef ROUTER_ROUND_ROBIN_EN
      mLast[q] = NI - 1;
`endif
    end
    mOutValid = '0;
    mInvalid  = '0;
  endtask

  // Reference arbitration: each non-full queue picks one holder of its id, searching in policy order.
  task automatic modelComb();
    int sel;
    bit g;
    for (int q = 0; q < NQ; q++) begin
      mWinner[q] = -1;
      if (!fullVec[q]) begin
        for (int k = 1; k <= NI; k++) begin
`ifdef ROUTER_ROUND_ROBIN_EN
          sel = (mLast[q] + k) % NI;
`else
          sel = k - 1;
`endif
          if (mWinner[q] < 0 && mHoldValid[sel] && mHoldId[sel] == q) mWinner[q] = sel;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      g = 1'b0;
      for (int q = 0; q < NQ; q++) if (mWinner[q] == i) g = 1'b1;
      mReady[i] = rstN && (!mHoldValid[i] || g);
    end
  endtask

  // One clock cycle: drive queue heads, check readiness, clock, advance model, check outputs.
  task automatic applyStimulus();
    bus.in_valid   = '0;
    bus.in_id      = '0;
    bus.in_packet  = '0;
    bus.queue_full = fullVec;
    for (int i = 0; i < NI; i++) begin
      accId[i]   = 0;
      accData[i] = '0;
    end
    if (pktQ0.size() > 0) begin
      bus.in_valid[0]  = 1'b1;
      bus.in_id[0]     = QW'(pktQ0[0].id);
      bus.in_packet[0] = pktQ0[0].data;
      accId[0]         = pktQ0[0].id;
      accData[0]       = pktQ0[0].data;
    end
    if (pktQ1.size() > 0) begin
      bus.in_valid[1]  = 1'b1;
      bus.in_id[1]     = QW'(pktQ1[0].id);
      bus.in_packet[1] = pktQ1[0].data;
      accId[1]         = pktQ1[0].id;
      accData[1]       = pktQ1[0].data;
    end
    #1;
    modelComb();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("in_ready[%0d]", i), bus.in_ready[i], mReady[i]);
      acc[i] = bus.in_valid[i] && mReady[i];
    end
    @(posedge clk);
    for (int q = 0; q < NQ; q++) begin
      if (mWinner[q] >= 0) begin
        mOutValid[q] = 1'b1;
        mOutPkt[q]   = mHoldPkt[mWinner[q]];
        mHoldValid[mWinner[q]] = 1'b0;
`ifdef ROUTER_ROUND_ROBIN_EN
        mLast[q] = mWinner[q];
`endif
      end else begin
        mOutValid[q] = 1'b0;
      end
    end
    for (int i = 0; i < NI; i++) begin
      mInvalid[i] = 1'b0;
      if (acc[i]) begin
        if (accId[i] < NQ) begin
          mHoldValid[i] = 1'b1;
          mHoldPkt[i]   = accData[i];
          mHoldId[i]    = accId[i];
        end else begin
          mHoldValid[i] = 1'b0;
          mInvalid[i]   = 1'b1;
        end
      end
    end
    if (acc[0]) void'(pktQ0.pop_front());
    if (acc[1]) void'(pktQ1.pop_front());
    #1;
    checkOutput("out_valid", bus.out_valid, mOutValid);
    checkOutput("invalid_id", bus.invalid_id, mInvalid);
    for (int q = 0; q < NQ; q++) begin
      out_t o;
      checkOutput($sformatf("out_packet[%0d]", q), bus.out_packet[q], mOutPkt[q]);
      if (bus.out_valid[q]) begin
        o.q    = q;
        o.data = bus.out_packet[q];
        outLog.push_back(o);
      end
    end
  endtask

  initial begin
    int k0, k3, kOther;
    logic [DW-1:0] collExp[8];

    fullVec         = '0;
    bus.in_valid    = '0;
    bus.in_id       = '0;
    bus.in_packet   = '0;
    bus.queue_full  = '0;
    busB.in_valid   = '0;
    busB.in_id      = '0;
    busB.in_packet  = '0;
    busB.queue_full = '0;
    modelReset();

    #1;
    checkOutput("reset in_ready", bus.in_ready, '0);
    checkOutput("reset out_valid", bus.out_valid, '0);
    checkOutput("reset invalid_id", bus.invalid_id, '0);
    for (int q = 0; q < NQ; q++) checkOutput("reset out_packet", bus.out_packet[q], '0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    $display("[TB] reset released");

    // Single packet: accept at the first edge, written after the second.
    outLog.delete();
    pushPkt(0, 2, 'hA5);
    applyStimulus();
    checkOutput("single edge1 out_valid", bus.out_valid, 4'b0000);
    applyStimulus();
    checkOutput("single edge2 out_valid", bus.out_valid, 4'b0100);
    checkOutput("single edge2 out_packet", bus.out_packet[2], 'hA5);
    applyStimulus();
    checkOutput("single edge3 out_valid", bus.out_valid, 4'b0000);

    // Collision on queue 1.
    outLog.delete();
    for (int k = 0; k < 4; k++) begin
      pushPkt(0, 1, 'h100 + k);
      pushPkt(1, 1, 'h200 + k);
    end
`ifdef ROUTER_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      collExp[2*k]   = 'h100 + k;
      collExp[2*k+1] = 'h200 + k;
    end
`else
    for (int k = 0; k < 4; k++) begin
      collExp[k]   = 'h100 + k;
      collExp[k+4] = 'h200 + k;
    end
`endif
    for (int c = 0; c < 30 && outLog.size() < 8; c++) applyStimulus();
    checkOutput("collision count", outLog.size(), 8);
    for (int k = 0; k < 8 && k < outLog.size(); k++) begin
      checkOutput("collision queue", outLog[k].q, 1);
      checkOutput($sformatf("collision order[%0d]", k), outLog[k].data, collExp[k]);
    end

    // Backpressure on queue 3.
    outLog.delete();
    fullVec[3] = 1'b1;
    pushPkt(1, 3, 'h300);
    pushPkt(1, 3, 'h301);
    for (int c = 0; c < 5; c++) applyStimulus();
    checkOutput("bp no write", outLog.size(), 0);
    checkOutput("bp in_ready[1] blocked", bus.in_ready[1], 1'b0);
    fullVec[3] = 1'b0;
    applyStimulus();
    checkOutput("bp release count", outLog.size(), 1);
    if (outLog.size() > 0) checkOutput("bp release data", outLog[0].data, 'h300);
    applyStimulus();
    checkOutput("bp in_ready[1] restored", bus.in_ready[1], 1'b1);
    checkOutput("bp second data", bus.out_packet[3], 'h301);

    // Parallel traffic on queues 0 and 3.
    outLog.delete();
    for (int k = 0; k < 8; k++) begin
      pushPkt(0, 0, 'h400 + k);
      pushPkt(1, 3, 'h500 + k);
    end
    for (int c = 0; c < 11; c++) applyStimulus();
    k0 = 0;
    k3 = 0;
    kOther = 0;
    foreach (outLog[k]) begin
      if (outLog[k].q == 0) begin
        checkOutput("parallel q0 order", outLog[k].data, 'h400 + k0);
        k0++;
      end else if (outLog[k].q == 3) begin
        checkOutput("parallel q3 order", outLog[k].data, 'h500 + k3);
        k3++;
      end else begin
        kOther++;
      end
    end
    checkOutput("parallel q0 count", k0, 8);
    checkOutput("parallel q3 count", k3, 8);
    checkOutput("parallel stray writes", kOther, 0);

    // Random traffic and random backpressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1 && pktQ0.size() < 3) pushPkt(0, $urandom_range(0, NQ-1), randData());
      if ($urandom_range(0, 1) == 1 && pktQ1.size() < 3) pushPkt(1, $urandom_range(0, NQ-1), randData());
      for (int q = 0; q < NQ; q++) fullVec[q] = ($urandom_range(0, 9) < 3);
      applyStimulus();
    end
    fullVec = '0;
    for (int c = 0; c < 12; c++) applyStimulus();

    // Reset while both holds are occupied and a write strobe is live.
    fullVec = 4'b0011;
    pushPkt(0, 2, 'hC1);
    pushPkt(0, 0, 'hC2);
    pushPkt(1, 1, 'hC3);
    applyStimulus();
    applyStimulus();
    checkOutput("pre-reset out_valid", bus.out_valid, 4'b0100);
    rstN = 1'b0;
    #1;
    checkOutput("async reset out_valid", bus.out_valid, '0);
    checkOutput("async reset in_ready", bus.in_ready, '0);
    pktQ0.delete();
    pktQ1.delete();
    modelReset();
    applyStimulus();
    applyStimulus();
    rstN = 1'b1;
    fullVec = '0;
    outLog.delete();
    pushPkt(1, 3, 'hBEEF);
    applyStimulus();
    checkOutput("post-reset edge1 writes", outLog.size(), 0);
    applyStimulus();
    checkOutput("post-reset edge2 out_valid", bus.out_valid, 4'b1000);
    checkOutput("post-reset edge2 data", bus.out_packet[3], 'hBEEF);
    for (int c = 0; c < 3; c++) applyStimulus();
    checkOutput("post-reset no stale writes", outLog.size(), 1);

    // Out-of-range id on the three-queue instance.
    busB.in_valid  = 2'b01;
    busB.in_id[0]  = 2'd3;
    busB.in_packet[0] = 8'h5A;
    #1;
    checkOutput("inv in_ready[0]", busB.in_ready[0], 1'b1);
    @(posedge clk);
    #1;
    busB.in_valid = '0;
    checkOutput("inv pulse", busB.invalid_id, 2'b01);
    checkOutput("inv out_valid edge1", busB.out_valid, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("inv pulse cleared", busB.invalid_id, 2'b00);
    checkOutput("inv out_valid edge2", busB.out_valid, 3'b000);
    busB.in_valid     = 2'b01;
    busB.in_id[0]     = 2'd2;
    busB.in_packet[0] = 8'h3C;
    @(posedge clk);
    #1;
    busB.in_valid = '0;
    checkOutput("inv valid id no pulse", busB.invalid_id, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("inv valid id out_valid", busB.out_valid, 3'b100);
    checkOutput("inv valid id data", busB.out_packet[2], 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_router.md
# packet_router

Parametrised packet router for the non-AXI domain. It takes packets from NUM_INPUTS packetizer ports and delivers each one, by its queue id, to one of NUMBER_OF_QUEUES queue write ports. Per-queue arbitration resolves simultaneous hits on the same queue, and per-queue full backpressure propagates to the packetizers through a valid/ready handshake. It replaces the fixed two-packetizer, four-queue dispatch pair, sitting between the packetizers and the Queue instances.

## Interface
Parameters:
- NUM_INPUTS, 2, number of packetizer ports (≥1)
- NUMBER_OF_QUEUES, 4, number of queue write ports (≥2)
- DATA_SIZE, 678, packet width in bits
- QID_WIDTH, $clog2(NUMBER_OF_QUEUES), width of the queue id field

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_packet  in  [NUM_INPUTS][DATA_SIZE]  packet per input
- in_valid  in  [NUM_INPUTS]  packet present
- in_id  in  [NUM_INPUTS][QID_WIDTH]  destination queue
- in_ready  out  [NUM_INPUTS]  input accepts this cycle
- queue_full  in  [NUMBER_OF_QUEUES]  queue cannot take a write
- out_packet  out  [NUMBER_OF_QUEUES][DATA_SIZE]  packet to queue (registered)
- out_valid  out  [NUMBER_OF_QUEUES]  one-cycle write strobe (registered)
- invalid_id  out  [NUM_INPUTS]  one-cycle pulse: accepted packet had id ≥ NUMBER_OF_QUEUES, discarded

## Operation
- Each input has one holding register: hold_valid, hold_packet, hold_id.
- Accept: in_valid & in_ready at an edge loads the holding register.
  - Exception: id ≥ NUMBER_OF_QUEUES. The packet is not held, and invalid_id pulses next cycle.
- in_ready = reset & (!hold_valid | hold_granted). Readiness is combinational, so one packet per cycle per input is sustained.
- Request: input i requests queue q when hold_valid[i] & hold_id[i]==q.
- Grant: queue q grants exactly one requester when queue_full[q]==0. No grant is given while queue_full[q]==1. Holds wait indefinitely and are never dropped.
- On grant, at the next edge:
  - out_packet[q] ← hold_packet of the winner
  - out_valid[q] ← 1
  - the winner's hold clears, unless it is simultaneously reloaded
- Non-granted queues get out_valid[q] ← 0. out_packet holds its last value.
- Different queues grant independently in the same cycle. Up to min(NUM_INPUTS, NUMBER_OF_QUEUES) writes per cycle.
- Arbitration policy per queue: round-robin or fixed priority, set by Configuration.
- Reset values: hold_valid=0, out_valid=0, out_packet=0, invalid_id=0, round-robin pointers=NUM_INPUTS-1, so input 0 has priority first. in_ready=0 while reset is low.
- Reset mid-operation discards all held packets. No partial writes are emitted.

## Timing
- Latency is 2 edges from accept to out_valid. Accept at edge E0, hold valid after E0, grant during cycle, out_valid high for the cycle after E1.
- queue_full is sampled combinationally in the grant cycle. It must reflect occupancy including any out_valid currently asserted. The queue guarantees this.
- Back-to-back: a granted hold is reloaded in the same edge, with no bubble.
- Losing inputs keep in_ready=0 until granted.

## Configuration
- ROUTER_ROUND_ROBIN_EN defined:
  - each queue keeps a QID-independent pointer last_grant[q]
  - the search starts at last_grant[q]+1, modulo NUM_INPUTS
  - the pointer updates only on grant
- Not defined: fixed priority, where the lowest input index wins. No pointer registers exist.

## Test plan
- Single packet: in0 id=2, data=0xA5, one cycle. Expected: out_valid[2] high exactly 2 edges later with out_packet[2]=0xA5; all other out_valid stay 0.
- Collision: in0 and in1 both id=1, held valid 4 cycles with distinct data. Expected:
  - with _EN: queue 1 alternates in0, in1, in0, in1
  - without _EN: in0 wins every cycle and in1 waits, with in_ready[1]=0 until in0 stops
- Backpressure: queue_full[3]=1 for 5 cycles while in1 targets id 3. Expected: in_ready[1]=0 after the first accept and no out_valid[3]. On release, the packet is written the next edge and in_ready[1] returns to 1.
- Parallel: in0 id=0 and in1 id=3 every cycle for 8 cycles. Expected: 8 writes on each queue, in order, with in_ready held at 1.
- Invalid id: NUMBER_OF_QUEUES=3, in0 id=3. Expected: invalid_id[0] pulses once and no out_valid.
- Reset: assert reset low with both holds full. Expected: out_valid=0 and in_ready=0 immediately; after release the first accepted packet emerges with latency 2 and the stale holds never appear.
